polyphony32_voice_scheduler: RTL

Voice allocator and per-frame sequencer in front of `polyphony32_mixer`. It takes note-on/note-off commands and maps each note onto one of 32 voice slots, stealing the least-recently-allocated voice when all slots are busy. On every sample-rate tick it walks the 32 slots through a single time-shared voice engine and packs the returned samples into the 512-bit `samples` bus. It then pulses `samples_ready` and drives an attenuation `multiplier` derived from the active-voice count.

---
 rtl/polyphony32_voice_scheduler.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/polyphony32_voice_scheduler.sv
// polyphony32_voice_scheduler
//
// Voice allocator and per-frame sequencer in front of polyphony32_mixer.
// Note-on/note-off commands are mapped onto 32 voice slots. When every slot
// is busy, the least-recently-allocated voice is stolen. On each frame_tick
// the 32 slots are walked in order through a single time-shared voice
// engine, and the returned samples are packed into a 512-bit frame.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   cmd_valid/on/note     command strobe, 1 = note-on / 0 = note-off, note
//   frame_tick            one-cycle sample-rate strobe
//   voice_req/idx/note    request to the voice engine (held until ack)
//   voice_ack/sample      engine response, sample is signed 16-bit
//   samples               packed frame, slot i at [16i+15:16i]
//   samples_ready         one-cycle pulse when a new frame is on samples
//   multiplier            mixer attenuation derived from active_count
//   active_count          number of active slots, 0..32
//   steal                 one-cycle pulse when a note-on steals a voice
//   overrun               one-cycle pulse when a frame_tick was dropped
module polyphony32_voice_scheduler (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  input  logic         cmd_on,
  input  logic [5:0]   cmd_note,
  input  logic         frame_tick,
  output logic         voice_req,
  output logic [4:0]   voice_idx,
  output logic [5:0]   voice_note,
  input  logic         voice_ack,
  input  logic [15:0]  voice_sample,
  output logic [511:0] samples,
  output logic         samples_ready,
  output logic [7:0]   multiplier,
  output logic [5:0]   active_count,
  output logic         steal,
  output logic         overrun
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT, S_DONE} seq_state_t;

  // Voice table. Active ranks form the dense set 0..count-1, rank 0 newest.
  logic [31:0] slot_active;
  logic [5:0]  slot_note [32];
  logic [4:0]  slot_rank [32];
  logic [5:0]  count_q;
  logic        steal_q;

  logic        hit;
  logic [4:0]  hit_idx;
  logic [4:0]  hit_rank;
  logic        free_found;
  logic [4:0]  free_idx;
  logic [4:0]  oldest_idx;

  // Lookup for the incoming command. Scanning from 31 down to 0 lets the
  // lowest matching index win. Inactive slots always carry rank 0, so the
  // rank-31 slot only exists (and is unique) when the table is full.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (slot_active[i] && (slot_note[i] == cmd_note)) begin
        hit     = 1'b1;
        hit_idx = 5'(i);
      end
      if (!slot_active[i]) begin
        free_found = 1'b1;
        free_idx   = 5'(i);
      end
      if (slot_rank[i] == 5'd31) begin
        oldest_idx = 5'(i);
      end
    end
    hit_rank = slot_rank[hit_idx];
  end

  // Table update. Later non-blocking writes to the chosen slot override the
  // bulk rank shift applied by the loop just before them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_active <= '0;
      count_q     <= '0;
      steal_q     <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        slot_note[i] <= '0;
        slot_rank[i] <= '0;
      end
    end else begin
      steal_q <= 1'b0;
      if (cmd_valid) begin
        if (cmd_on) begin
          if (hit) begin
            for (int i = 0; i < 32; i++) begin
              if (slot_active[i] && (slot_rank[i] < hit_rank)) begin
                slot_rank[i] <= slot_rank[i] + 5'd1;
              end
            end
            slot_rank[hit_idx] <= '0;
          end else if (free_found) begin
            for (int i = 0; i < 32; i++) begin
              if (slot_active[i]) begin
                slot_rank[i] <= slot_rank[i] + 5'd1;
              end
            end
            slot_active[free_idx] <= 1'b1;
            slot_note[free_idx]   <= cmd_note;
            slot_rank[free_idx]   <= '0;
            count_q               <= count_q + 6'd1;
          end else begin
            for (int i = 0; i < 32; i++) begin
              slot_rank[i] <= slot_rank[i] + 5'd1;
            end
            slot_note[oldest_idx] <= cmd_note;
            slot_rank[oldest_idx] <= '0;
            steal_q               <= 1'b1;
          end
        end else if (hit) begin
          for (int i = 0; i < 32; i++) begin
            if (slot_active[i] && (slot_rank[i] > hit_rank)) begin
              slot_rank[i] <= slot_rank[i] - 5'd1;
            end
          end
          slot_active[hit_idx] <= 1'b0;
          slot_rank[hit_idx]   <= '0;
          count_q              <= count_q - 6'd1;
        end
      end
    end
  end

  // Frame sequencer.
  seq_state_t  state_q;
  seq_state_t  state_d;
  logic [4:0]   idx_q;
  logic [511:0] staging_q;
  logic [511:0] samples_q;
  logic [7:0]   mult_q;
  logic [7:0]   mult_now;
  logic [4:0]   voice_idx_q;
  logic [5:0]   voice_note_q;
  logic         overrun_q;
  logic         last_slot;
  logic         cur_active;

  assign last_slot  = (idx_q == 5'd31);
  assign cur_active = slot_active[idx_q];
  assign mult_now   = (count_q == 6'd32) ? 8'hFF : {count_q[4:0], 3'b000};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (frame_tick) state_d = S_SCAN;
      S_SCAN: begin
        if (cur_active)     state_d = S_WAIT;
        else if (last_slot) state_d = S_DONE;
      end
      S_WAIT: begin
        if (voice_ack) state_d = last_slot ? S_DONE : S_SCAN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: slot cursor, staging frame, latched request and held outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q        <= '0;
      staging_q    <= '0;
      samples_q    <= '0;
      mult_q       <= '0;
      voice_idx_q  <= '0;
      voice_note_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= frame_tick && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: if (frame_tick) idx_q <= '0;
        S_SCAN: begin
          if (cur_active) begin
            voice_idx_q  <= idx_q;
            voice_note_q <= slot_note[idx_q];
          end else begin
            staging_q[{idx_q, 4'b0000} +: 16] <= 16'h0000;
            if (!last_slot) idx_q <= idx_q + 5'd1;
          end
        end
        S_WAIT: begin
          if (voice_ack) begin
            staging_q[{idx_q, 4'b0000} +: 16] <= voice_sample;
            if (!last_slot) idx_q <= idx_q + 5'd1;
          end
        end
        S_DONE: begin
          samples_q <= staging_q;
          mult_q    <= mult_now;
        end
        default: ;
      endcase
    end
  end

  // In DONE the fresh frame and multiplier are shown directly so they line
  // up with samples_ready; afterwards the held copies keep the bus stable.
  assign voice_req     = (state_q == S_WAIT);
  assign voice_idx     = voice_idx_q;
  assign voice_note    = voice_note_q;
  assign samples_ready = (state_q == S_DONE);
  assign samples       = (state_q == S_DONE) ? staging_q : samples_q;
  assign multiplier    = (state_q == S_DONE) ? mult_now : mult_q;
  assign active_count  = count_q;
  assign steal         = steal_q;
  assign overrun       = overrun_q;

endmodule
